rk_readback_decoder: RTL
========================

// Module: rk_readback_decoder
// PURPOSE
//  Reads back the round-key planes written into the DRAM-CIM array, checks them, and rebuilds the 11 AES-128 round keys.
//  - Read order: WBL word rows at addr 0,1,2 (true) and 32,33,34 (inverted).
//  - Reverses the WBL bit-matrix packing (row=key byte pair, column=round).
//  - Reports per-bit inversion mismatches.
//  - Sits between the array read port and the AES datapath/test controller.
// PARAMETERS
//  RD_LAT   2   array read latency in cycles, rd_req to rsp_valid (legal 1..4)
// PORTS
//  clk          in   1    single clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  start        in   1    pulse: begin a readback pass (ignored unless IDLE or DONE)
//  rd_req       out  1    array read request, one per cycle
//  rd_addr      out  6    array address: 0,1,2,32,33,34
//  rd_word      out  4    WBL word select 0..15 (0..7 even bytes bit7..0, 8..15 odd bytes bit7..0)
//  rsp_valid    in   1    read data valid, exactly RD_LAT cycles after rd_req
//  rsp_data     in   64   read word; byte col c = bits[63-8c -: 8], row r = bit (63-8c-r)
//  busy         out  1    pass in progress
//  done         out  1    high in DONE until next start
//  err          out  1    sticky mismatch flag, cleared on start
//  err_cnt      out  8    saturating mismatch-bit count, cleared on start
//  rk_idx       in   4    round-key select 0..10 (>10 reads zero)
//  rk_data      out  128  rebuilt round key rk[rk_idx], combinational from store
// BEHAVIOUR
//  Reset:
//  - All outputs are 0.
//  - The round-key store (11x128 flops) is cleared.
//  - FSM enters IDLE.
//  Reset mid-pass aborts immediately. No partial state survives.
//  FSM states:
//  - IDLE: on start, go to ISSUE.
//  - ISSUE: issue 96 reads, then go to DRAIN.
//  - DRAIN: wait until the tag pipe is empty, then go to DONE.
//  - DONE: on start, go to ISSUE.
//  ISSUE sequencing:
//  - rd_req is high every cycle.
//  - Address order is 0,1,2,32,33,34. Word 0..15 is the inner loop, address is the outer loop.
//  - The word counter wraps 15->0 and the address advances.
//  Tagging:
//  - An RD_LAT-deep shift register carries {valid,addr_idx,word} alongside each request.
//  - A response is consumed when rsp_valid is high and the tag at the pipe head is valid.
//  - A rsp_valid with no matching tag is ignored and sets err.
//  Decode, for a word at address idx a:
//  - Round base: ra = a mod 32.
//  - Byte parity: odd = word[3].
//  - Bit position: b = 7 - word[2:0].
//  - For c = 0..3 and r = 0..7: rnd = 4*ra + c, src = rsp_data[63-8c-r], dst = rk[rnd][120-16r-8*odd+b].
//  - Only rnd <= 10 is written or checked.
//  - Byte columns 4..7 (bits 31:0) are ignored.
//  True pass (a in 0..2):
//  - Write dst = src.
//  - Padding bit (ra=2, c=3) must read 0, otherwise it counts as a mismatch.
//  Inverted pass (a in 32..34):
//  - No writes.
//  - Mismatch whenever src == dst.
//  - Padding bit must read 1.
//  Error counting:
//  - err_cnt adds popcount of the mismatches in each word and saturates at 255.
//  - err sets if any mismatch occurs.
//  Completion:
//  - done and busy change on the DRAIN->DONE edge.
//  - Total latency from start to done is 96+RD_LAT+1 cycles.
//  start during ISSUE/DRAIN is ignored.
//  The rk store keeps the last pass's contents until the next true-pass writes overwrite them.
// STRUCTURE
//  Shared package, cim_aes_pkg:
//  - NUM_RK=11, WBL_WORDS=16
//  - address constant list {0,1,2,32,33,34}
//  - state enum {IDLE,ISSUE,DRAIN,DONE}
//  Sub-module rk_bit_scatter (combinational): given ra, odd, b and rsp_data, produces
//  - per-round 128-bit write-enable/data masks
//  - compare vectors
//  The top level holds the FSM, tag pipe, store and counters.
// TESTING
//  Golden: array model preloaded with golden WBL words for Kin=2b7e151628aed2a6abf7158809cf4f3c.
//  1 Clean pass:
//    - Drive a start pulse.
//    - Require done after 99 cycles (RD_LAT=2), err=0.
//    - Require rk_idx=0 -> 2b7e1516...4f3c and rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2 Inversion fault: flip bit 63 of addr-33 word 0. Require err=1, err_cnt=1, rk store still correct.
//  3 Padding fault: set addr-2 word 5 bit 39 (c=3,r=0) to 1. Require err_cnt=1.
//  4 Reset abort: assert rst_n low at cycle 40. Require all outputs 0 and every rk_data 0. A restart then matches test 1.
//  5 Busy start: pulse start at cycle 10.
//    - Require the read sequence is unaffected.
//    - Require exactly 96 rd_req in the pass.
//    - Rerun with RD_LAT=1 and RD_LAT=4: done after 98 and 101 cycles.
//  6 Spurious rsp_valid in IDLE: require err=1 and no store change. Then start clears err.

Source files
------------

// File: rtl/cim_aes_pkg.sv
// cim_aes_pkg: shared constants, state encoding and tag format for the CIM AES round-key readback.
package cim_aes_pkg;

    localparam int NUM_RK    = 11;
    localparam int WBL_WORDS = 16;
    localparam int NUM_ADDR  = 6;

    // Array rows in read order: three true rows, then their inverted copies.
    localparam logic [NUM_ADDR-1:0][5:0] ADDR_LIST = {6'd34, 6'd33, 6'd32, 6'd2, 6'd1, 6'd0};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef logic [NUM_RK-1:0][127:0] rk_store_t;

    typedef struct packed {
        logic       v;
        logic [2:0] ai;
        logic [3:0] w;
    } tag_t;

    function automatic logic [5:0] popcount32(input logic [31:0] x);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n += 6'(x[i]);
        return n;
    endfunction

endpackage

// File: rtl/rk_bit_scatter.sv
// rk_bit_scatter: maps one WBL read word onto round-key bit positions and flags per-bit mismatches.
module rk_bit_scatter
    import cim_aes_pkg::*;
(
    input  logic [1:0]  ra,
    input  logic        odd,
    input  logic [2:0]  b,
    input  logic        inv,
    input  logic [63:0] data,
    input  rk_store_t   rk,
    output rk_store_t   wen,
    output rk_store_t   wdat,
    output logic [31:0] miss
);

    logic [3:0] rnd;
    logic [6:0] pos;
    logic       src;

    always_comb begin
        wen  = '0;
        wdat = '0;
        miss = '0;
        rnd  = '0;
        pos  = '0;
        src  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 8; r++) begin
                rnd = {ra, 2'(c)};
                pos = 7'(120 - 16 * r - 8 * int'(odd) + int'(b));
                src = data[63-8*c-r];
                if (rnd <= 4'd10) begin
                    wen[rnd][pos]  = 1'b1;
                    wdat[rnd][pos] = src;
                    miss[8*c+r]    = inv & (src == rk[rnd][pos]);
                end else if (rnd == 4'd11) begin
                    // Padding column: 0 in the true rows, 1 in the inverted rows.
                    miss[8*c+r] = src ^ inv;
                end
            end
        end
    end

endmodule

// File: rtl/rk_readback_decoder.sv
// rk_readback_decoder: reads the round-key planes back from the CIM array, checks the
// inverted copies and rebuilds the 11 AES-128 round keys.
module rk_readback_decoder
    import cim_aes_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         rd_req,
    output logic [5:0]   rd_addr,
    output logic [3:0]   rd_word,
    input  logic         rsp_valid,
    input  logic [63:0]  rsp_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [7:0]   err_cnt,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data
);

    state_t                 state, state_nx;
    logic      [2:0]        ai;
    logic      [3:0]        wd;
    tag_t      [RD_LAT-1:0] pipe;
    tag_t                   head;
    rk_store_t              rk, wen, wdat;
    logic      [31:0]       miss;
    logic      [8:0]        sum;
    logic      [1:0]        ra;
    logic                   inv, consume, spurious, pipe_busy, last_req, kick;

    assign rd_req   = state == ISSUE;
    assign rd_addr  = rd_req ? ADDR_LIST[ai] : '0;
    assign rd_word  = rd_req ? wd : '0;
    assign busy     = state == ISSUE || state == DRAIN;
    assign done     = state == DONE;
    assign rk_data  = rk_idx <= 4'd10 ? rk[rk_idx] : '0;

    assign head     = pipe[RD_LAT-1];
    assign consume  = rsp_valid & head.v;
    assign spurious = rsp_valid & ~head.v;
    assign inv      = head.ai >= 3'd3;
    assign ra       = 2'(inv ? head.ai - 3'd3 : head.ai);
    assign last_req = ai == 3'(NUM_ADDR - 1) && wd == 4'(WBL_WORDS - 1);
    assign kick     = start && (state == IDLE || state == DONE);
    assign sum      = {1'b0, err_cnt} + {3'b0, popcount32(miss)};

    rk_bit_scatter u_scatter (
        .ra   (ra),
        .odd  (head.w[3]),
        .b    (~head.w[2:0]),
        .inv  (inv),
        .data (rsp_data),
        .rk   (rk),
        .wen  (wen),
        .wdat (wdat),
        .miss (miss)
    );

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) pipe_busy |= pipe[i].v;
    end

    always_comb begin
        state_nx = state;
        state_nx = state == ISSUE ? (last_req ? DRAIN : ISSUE) :
                   state == DRAIN ? (pipe_busy ? DRAIN : DONE) :
                   kick           ? ISSUE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ai      <= '0;
            wd      <= '0;
            pipe    <= '0;
            rk      <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_nx;
            pipe[0] <= tag_t'({rd_req, ai, wd});
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
            if (kick) begin
                ai      <= '0;
                wd      <= '0;
                err     <= 1'b0;
                err_cnt <= '0;
            end else begin
                if (rd_req) begin
                    wd <= wd + 4'd1;
                    if (wd == 4'(WBL_WORDS - 1)) ai <= last_req ? 3'd0 : ai + 3'd1;
                end
                if (spurious || (consume && |miss)) err <= 1'b1;
                if (consume) err_cnt <= sum[8] ? 8'hff : sum[7:0];
                // Only the true rows carry key data; the inverted rows are compare-only.
                if (consume && !inv) rk <= (rk & ~wen) | wdat;
            end
        end
    end

endmodule
